// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
//  Shared width helpers for the fifo_flags FIFO and its pointer sub-module.
//   cnt_w(depth)  : bits needed to hold an occupancy of 0..depth
//   ptr_w(depth)  : bits needed to address 0..depth-1 (at least 1)
//   wrap_inc(p,d) : p+1 with explicit wrap from d-1 back to 0
//  Optional feature macro used by fifo_flags: FIFO_FWFT_EN
// ----------------------------------------------------------------------------
package fifo_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int wrap_inc(input int p, input int depth);
        return (p == depth - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// ----------------------------------------------------------------------------
// fifo_wrap_ptr
//  Circular address counter for the FIFO. Increments on inc and wraps
//  DEPTH-1 -> 0 by compare-and-clear, so any DEPTH works.
//  Ports:
//   clk  in   clock (rising edge)
//   rst  in   asynchronous active-high reset, pointer -> 0
//   inc  in   advance the pointer this cycle
//   ptr  out  current pointer value [PW-1:0]
// ----------------------------------------------------------------------------
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PW    = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0] ptr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (inc) begin
            ptr_reg <= (ptr_reg == LAST) ? '0 : ptr_reg + PW'(1);
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_flags.sv
// ----------------------------------------------------------------------------
// fifo_flags
//  Single-clock FIFO of any DEPTH >= 2 with registered status flags,
//  programmable almost-full / almost-empty thresholds and sticky
//  overflow / underflow error flags.
//  Optional macro FIFO_FWFT_EN selects first-word-fall-through: r_data shows
//  the head word whenever the FIFO is not empty and r_req pops it. Without
//  the macro r_data is loaded one cycle after an accepted read and held
//  otherwise.
//  Ports:
//   clk, rst          clock / asynchronous active-high reset
//   w_req, w_data     write request and data
//   r_req, r_data     read (pop) request and registered read data
//   cnt               number of stored words
//   empty, full       cnt == 0 / cnt == DEPTH
//   almost_empty      cnt <= AE_THR
//   almost_full       cnt >= AF_THR
//   err_clr           clears overflow/underflow (wins over a same-cycle set)
//   overflow          sticky: write attempted while full with no pop
//   underflow         sticky: read attempted while empty
// ----------------------------------------------------------------------------
module fifo_flags
    import fifo_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16,
    parameter int AF_THR = 6,
    parameter int AE_THR = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_req,
    input  logic [DATA_W-1:0]        w_data,
    input  logic                     r_req,
    output logic [DATA_W-1:0]        r_data,
    output logic [cnt_w(DEPTH)-1:0]  cnt,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    input  logic                     err_clr,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int CW = cnt_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_THR);
    localparam logic [CW-1:0] AE_C   = CW'(AE_THR);

    // Parameter legality, reported at elaboration.
    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_flags: DEPTH must be >= 2");
    end
    if (AF_THR < 1 || AF_THR > DEPTH) begin : g_bad_af
        $error("fifo_flags: AF_THR must be in 1..DEPTH");
    end
    if (AE_THR < 0 || AE_THR > DEPTH - 1) begin : g_bad_ae
        $error("fifo_flags: AE_THR must be in 0..DEPTH-1");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PW-1:0]     w_ptr;
    logic [PW-1:0]     r_ptr;
    logic              wr_ok;
    logic              rd_ok;
    logic [CW-1:0]     cnt_reg;
    logic [CW-1:0]     cnt_next;
    logic              empty_reg;
    logic              full_reg;
    logic              almost_empty_reg;
    logic              almost_full_reg;
    logic              overflow_reg;
    logic              underflow_reg;
    logic [DATA_W-1:0] r_data_reg;

    // A write to a full FIFO still succeeds when the same cycle pops a word.
    always_comb begin
        rd_ok = r_req && !empty_reg;
        wr_ok = w_req && (!full_reg || rd_ok);
        case ({wr_ok, rd_ok})
            2'b10:   cnt_next = cnt_reg + CW'(1);
            2'b01:   cnt_next = cnt_reg - CW'(1);
            default: cnt_next = cnt_reg;
        endcase
    end

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_w_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_ok),
        .ptr (w_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_r_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_ok),
        .ptr (r_ptr)
    );

    // Storage is not reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[w_ptr] <= w_data;
        end
    end

    // Flags are derived from the next count so they change on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg          <= '0;
            empty_reg        <= 1'b1;
            full_reg         <= 1'b0;
            almost_empty_reg <= 1'b1;
            almost_full_reg  <= 1'b0;
            overflow_reg     <= 1'b0;
            underflow_reg    <= 1'b0;
        end else begin
            cnt_reg          <= cnt_next;
            empty_reg        <= (cnt_next == '0);
            full_reg         <= (cnt_next == FULL_C);
            almost_empty_reg <= (cnt_next <= AE_C);
            almost_full_reg  <= (cnt_next >= AF_C);
            overflow_reg     <= err_clr ? 1'b0
                              : (overflow_reg  || (w_req && full_reg && !rd_ok));
            underflow_reg    <= err_clr ? 1'b0
                              : (underflow_reg || (r_req && empty_reg));
        end
    end

`ifdef FIFO_FWFT_EN
    // Preload the word that will be at the head after this edge. When the
    // write lands exactly at the new head (FIFO empty after any pop), the
    // incoming data is forwarded because it is not yet in the array.
    logic [PW-1:0]     r_ptr_next;
    logic [DATA_W-1:0] head_next;

    always_comb begin
        r_ptr_next = rd_ok ? PW'(wrap_inc(int'(r_ptr), DEPTH)) : r_ptr;
        if (wr_ok && (w_ptr == r_ptr_next)) begin
            head_next = w_data;
        end else begin
            head_next = mem[r_ptr_next];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_reg <= '0;
        end else if (cnt_next != '0) begin
            r_data_reg <= head_next;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_reg <= '0;
        end else if (rd_ok) begin
            r_data_reg <= mem[r_ptr];
        end
    end
`endif

    assign r_data       = r_data_reg;
    assign cnt          = cnt_reg;
    assign empty        = empty_reg;
    assign full         = full_reg;
    assign almost_empty = almost_empty_reg;
    assign almost_full  = almost_full_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_flags.sv
// ----------------------------------------------------------------------------
// tb_fifo_flags
//  Directed bench for fifo_flags. Two instances share stimulus: DEPTH=8 for
//  the flag/threshold/error sequences and DEPTH=5 for the non-power-of-two
//  wrap sequence. Works in both read modes (FIFO_FWFT_EN defined or not).
// ----------------------------------------------------------------------------
module tb_fifo_flags;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w_req = 1'b0;
    logic [15:0] w_data = '0;
    logic        r_req = 1'b0;
    logic        err_clr = 1'b0;

    logic [15:0] r_data;
    logic [3:0]  cnt;
    logic        empty, full, almost_empty, almost_full, overflow, underflow;

    logic [15:0] r_data5;
    logic [2:0]  cnt5;
    logic        empty5, full5, almost_empty5, almost_full5, overflow5, underflow5;

    int n_checks = 0;
    int n_errors = 0;
    bit check5 = 1'b0;
    int occ = 0;

    always #5 clk = ~clk;

    fifo_flags #(.DEPTH(8), .DATA_W(16), .AF_THR(6), .AE_THR(2)) dut (
        .clk(clk), .rst(rst), .w_req(w_req), .w_data(w_data), .r_req(r_req),
        .r_data(r_data), .cnt(cnt), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full),
        .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
    );

    fifo_flags #(.DEPTH(5), .DATA_W(16), .AF_THR(4), .AE_THR(1)) dut5 (
        .clk(clk), .rst(rst), .w_req(w_req), .w_data(w_data), .r_req(r_req),
        .r_data(r_data5), .cnt(cnt5), .empty(empty5), .full(full5),
        .almost_empty(almost_empty5), .almost_full(almost_full5),
        .err_clr(err_clr), .overflow(overflow5), .underflow(underflow5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop one word expected to be exp, optionally writing wdata in the same cycle.
    task automatic pop_word(input logic [15:0] exp, input bit also_write, input logic [15:0] wdata);
`ifdef FIFO_FWFT_EN
        chk("rd_head", r_data, exp);
        if (check5) chk("rd_head5", r_data5, exp);
`endif
        r_req  = 1'b1;
        w_req  = also_write;
        w_data = wdata;
        tick();
        r_req  = 1'b0;
        w_req  = 1'b0;
`ifndef FIFO_FWFT_EN
        chk("rd_data", r_data, exp);
        if (check5) chk("rd_data5", r_data5, exp);
`endif
        $display("pop exp=%04h r_data=%04h cnt=%0d", exp, r_data, cnt);
    endtask

    task automatic push_word(input logic [15:0] d);
        w_req  = 1'b1;
        w_data = d;
        tick();
        w_req  = 1'b0;
        $display("push %04h cnt=%0d", d, cnt);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_cnt", cnt, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ae", almost_empty, 1);
        chk("rst_af", almost_full, 0);
        chk("rst_rdata", r_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        rst = 1'b0;

        // 1: fill with 1..8, watch thresholds
        for (int i = 1; i <= 8; i++) begin
            push_word(16'(i));
            chk("fill_cnt", cnt, i);
            chk("fill_ae", almost_empty, (i <= 2) ? 1 : 0);
            chk("fill_af", almost_full, (i >= 6) ? 1 : 0);
            chk("fill_empty", empty, 0);
        end
        chk("fill_full", full, 1);

        // 2: write while full is dropped
        push_word(16'hDEAD);
        chk("ovf_set", overflow, 1);
        chk("ovf_cnt", cnt, 8);
        chk("ovf_full", full, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        // 3: simultaneous write+read while full, 4 cycles
        for (int i = 1; i <= 4; i++) begin
            pop_word(16'(i), 1'b1, 16'(8 + i));
            chk("wr_rd_cnt", cnt, 8);
            chk("wr_rd_full", full, 1);
            chk("wr_rd_ovf", overflow, 0);
        end
        // drain: 0xDEAD never appears
        for (int i = 5; i <= 12; i++) begin
            pop_word(16'(i), 1'b0, 16'h0);
            chk("drain_cnt", cnt, 12 - i);
        end
        chk("drain_empty", empty, 1);
        chk("drain_ae", almost_empty, 1);
        chk("drain_af", almost_full, 0);

        // 4: read while empty
        r_req = 1'b1;
        tick();
        r_req = 1'b0;
        chk("udf_set", underflow, 1);
        chk("udf_cnt", cnt, 0);
`ifndef FIFO_FWFT_EN
        chk("udf_rdata_hold", r_data, 16'h000C);
`endif
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("udf_clr", underflow, 0);
        // clear wins over a same-cycle set
        r_req = 1'b1;
        err_clr = 1'b1;
        tick();
        r_req = 1'b0;
        err_clr = 1'b0;
        chk("udf_clr_prio", underflow, 0);
        // empty + write + read: write taken, read rejected
        w_req = 1'b1;
        r_req = 1'b1;
        w_data = 16'h0055;
        tick();
        w_req = 1'b0;
        r_req = 1'b0;
        chk("ewr_cnt", cnt, 1);
        chk("ewr_udf", underflow, 1);
        chk("ewr_empty", empty, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        pop_word(16'h0055, 1'b0, 16'h0);
        chk("ewr_drained", empty, 1);

        // Reset in the middle of a write burst
        w_req = 1'b1;
        w_data = 16'h0077;
        tick();
        tick();
        tick();
        chk("burst_cnt", cnt, 3);
        rst = 1'b1;
        #2;
        chk("midrst_cnt", cnt, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_cnt5", cnt5, 0);
        chk("midrst_rdata", r_data, 0);
        w_req = 1'b0;
        tick();
        rst = 1'b0;
        $display("mid-burst reset cnt=%0d empty=%0d", cnt, empty);

        // 6: write to empty, head visibility
        push_word(16'h00AA);
        chk("aa_empty", empty, 0);
        chk("aa_cnt", cnt, 1);
`ifdef FIFO_FWFT_EN
        chk("aa_fwft_head", r_data, 16'h00AA);
`else
        chk("aa_std_hold", r_data, 16'h0000);
`endif
        check5 = 1'b1;
        pop_word(16'h00AA, 1'b0, 16'h0);
        chk("aa_empty_after", empty, 1);
        chk("aa_empty5_after", empty5, 1);

        // 5: 20 writes with reads and random idle gaps, wrap on DEPTH 8 and 5
        occ = 0;
        for (int k = 0; k < 20; k++) begin
            push_word(16'h1000 + 16'(k));
            occ++;
            chk("seq_cnt", cnt, occ);
            chk("seq_cnt5", cnt5, occ);
            repeat ($urandom_range(0, 2)) tick();
            if (k % 3 == 2) begin
                for (int j = 2; j >= 0; j--) begin
                    pop_word(16'h1000 + 16'(k - j), 1'b0, 16'h0);
                    occ--;
                    repeat ($urandom_range(0, 1)) tick();
                end
            end
        end
        pop_word(16'h1012, 1'b0, 16'h0);
        pop_word(16'h1013, 1'b0, 16'h0);
        chk("seq_empty", empty, 1);
        chk("seq_empty5", empty5, 1);
        chk("seq_udf5", underflow5, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog: the stimulus is bounded, this only guards against a stuck clock.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
